pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter MDU_LATENCY, default 32, cycles a mult/div occupies the multiply/divide unit (legal range 2..255).
REQ-002 Parameter PERF_W, default 32, width of the stall-cycle performance counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 id_rs  input  5  decode-stage rs register index.
REQ-006 id_rt  input  5  decode-stage rt register index.
REQ-007 id_uses_rt  input  1  decode instruction reads rt.
REQ-008 id_mdu_op  input  1  decode instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-009 ex_mem_read  input  1  execute-stage instruction is a load.
REQ-010 ex_rt  input  5  load destination register in execute.
REQ-011 ex_branch_taken  input  1  execute resolved a taken branch/jump this cycle.
REQ-012 ex_branch_target  input  32  redirect address.
REQ-013 mdu_start  input  1  single-cycle pulse: execute issued mult/div.
REQ-014 stall_fetch  output  1  hold PC and fetch register (drives the fetch unit's stall_fetch).
REQ-015 stall_decode  output  1  hold IF/ID register.
REQ-016 flush_decode  output  1  squash IF/ID contents.
REQ-017 bubble_execute  output  1  insert NOP into ID/EX.
REQ-018 redirect_valid  output  1  load redirect_pc into PC.
REQ-019 redirect_pc  output  32  next PC on redirect.
REQ-020 mdu_busy  output  1  multiply/divide unit occupied.
REQ-021 mdu_overlap_err  output  1  sticky: mdu_start while busy.
REQ-022 stall_cycles  output  PERF_W  saturating count of cycles with stall_fetch=1.
REQ-023 flush_count  output  16  saturating count of redirects.

Function
REQ-024 Load-use hazard = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)), combinational, same cycle.
REQ-025 MDU hazard = mdu_busy & id_mdu_op, combinational.
REQ-026 FSM states: IDLE, MDU_WAIT; IDLE->MDU_WAIT on mdu_start, loading down-counter with MDU_LATENCY-1.
REQ-027 In MDU_WAIT the counter decrements each cycle; on the cycle it equals 0 the FSM returns to IDLE at the next edge; mdu_busy=1 exactly MDU_LATENCY cycles starting the cycle after mdu_start.
REQ-028 mdu_start in MDU_WAIT is ignored (counter unchanged) and sets mdu_overlap_err until reset.
REQ-029 Priority 1 -- ex_branch_taken: redirect_valid=1, redirect_pc=ex_branch_target, flush_decode=1, bubble_execute=1, stall_fetch=0, stall_decode=0, same cycle; overrides any hazard.
REQ-030 Priority 2 -- load-use or MDU hazard (no branch): stall_fetch=1, stall_decode=1, bubble_execute=1, flush_decode=0, redirect_valid=0.
REQ-031 Otherwise all control outputs 0; redirect_pc = ex_branch_target whenever redirect_valid=0 (don't-care for consumers).
REQ-032 A taken branch during MDU_WAIT does not alter the FSM or counter (mult/div already in flight).
REQ-033 Simultaneous mdu_start and ex_branch_taken: both take effect.
REQ-034 stall_cycles increments on each cycle stall_fetch=1, flush_count on each redirect_valid=1; both saturate at all-ones, never wrap.

Reset
REQ-035 While rst_n=0: FSM=IDLE, counter=0, mdu_busy=0, mdu_overlap_err=0, stall_cycles=0, flush_count=0, and stall_fetch, stall_decode, flush_decode, bubble_execute, redirect_valid forced 0.
REQ-036 Reset asserted mid-MDU_WAIT aborts the wait immediately; first cycle after deassertion is IDLE.

Structure
REQ-037 Shared package mips_ctrl_pkg holds the FSM state type, MDU_LATENCY default and register-index width constant.
REQ-038 One sub-module sat_counter (parameterised width, inc, rst_n) instantiated twice for the performance counters.

Verification
REQ-039 Load r5 in EX (ex_rt=5), decode id_rs=5 -> stall_fetch=stall_decode=bubble_execute=1 for that cycle only; ex_rt=0 case -> no stall.
REQ-040 mdu_start at cycle 10, MDU_LATENCY=32, id_mdu_op held 1 -> mdu_busy cycles 11..42, stall_fetch 1 over same window, stall_cycles=32.
REQ-041 Load-use hazard plus ex_branch_taken, target 0x0040_0100 -> redirect_valid=1, redirect_pc=0x0040_0100, flush_decode=1, stall_fetch=0, flush_count=1.
REQ-042 Second mdu_start at busy cycle 5 -> mdu_overlap_err=1 sticky, busy still ends at original cycle.
REQ-043 rst_n low at busy cycle 7 -> all outputs 0 immediately, mdu_busy 0 after release.
REQ-044 stall_fetch held 1 with PERF_W=4 -> stall_cycles reaches 15 and holds.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam int C_REG_IDX_W           = 5;
    localparam int C_MDU_LATENCY_DEFAULT = 32;
    // Wide enough for the largest legal latency reload (254).
    localparam int C_MDU_CNT_W           = 8;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MDU_WAIT = 1'b1
    } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Load-use / MDU stall, branch redirect and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = C_MDU_LATENCY_DEFAULT,
    parameter int PERF_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [C_REG_IDX_W-1:0] id_rs,
    input  logic [C_REG_IDX_W-1:0] id_rt,
    input  logic                   id_uses_rt,
    input  logic                   id_mdu_op,
    input  logic                   ex_mem_read,
    input  logic [C_REG_IDX_W-1:0] ex_rt,
    input  logic                   ex_branch_taken,
    input  logic [31:0]            ex_branch_target,
    input  logic                   mdu_start,
    output logic                   stall_fetch,
    output logic                   stall_decode,
    output logic                   flush_decode,
    output logic                   bubble_execute,
    output logic                   redirect_valid,
    output logic [31:0]            redirect_pc,
    output logic                   mdu_busy,
    output logic                   mdu_overlap_err,
    output logic [PERF_W-1:0]      stall_cycles,
    output logic [15:0]            flush_count
);

    localparam logic [C_MDU_CNT_W-1:0] C_MDU_RELOAD = C_MDU_CNT_W'(MDU_LATENCY - 1);

    mdu_state_t             r_state;
    mdu_state_t             w_next_state;
    logic [C_MDU_CNT_W-1:0] r_mdu_cnt;
    logic [C_MDU_CNT_W-1:0] w_next_mdu_cnt;
    logic                   r_overlap_err;
    logic                   w_load_use;
    logic                   w_mdu_hazard;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign w_load_use = ex_mem_read && (ex_rt != '0) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign mdu_busy     = (r_state == ST_MDU_WAIT);
    assign w_mdu_hazard = mdu_busy && id_mdu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mdu_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_mdu_cnt <= w_next_mdu_cnt;
        end
    end

    // Branches never touch the MDU sequencer: the operation is already in flight.
    always_comb begin
        w_next_state   = r_state;
        w_next_mdu_cnt = r_mdu_cnt;
        case (r_state)
            ST_IDLE: begin
                if (mdu_start) begin
                    w_next_state   = ST_MDU_WAIT;
                    w_next_mdu_cnt = C_MDU_RELOAD;
                end
            end
            ST_MDU_WAIT: begin
                if (r_mdu_cnt == '0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_mdu_cnt = r_mdu_cnt - C_MDU_CNT_W'(1);
                end
            end
            default: begin
                w_next_state   = ST_IDLE;
                w_next_mdu_cnt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overlap_err <= 1'b0;
        end else if (mdu_start && mdu_busy) begin
            r_overlap_err <= 1'b1;
        end
    end

    assign mdu_overlap_err = r_overlap_err;

    // Redirect beats stalls; controls are gated off while reset is held.
    always_comb begin
        stall_fetch    = 1'b0;
        stall_decode   = 1'b0;
        flush_decode   = 1'b0;
        bubble_execute = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = ex_branch_target;
        if (rst_n) begin
            if (ex_branch_taken) begin
                redirect_valid = 1'b1;
                flush_decode   = 1'b1;
                bubble_execute = 1'b1;
            end else if (w_load_use || w_mdu_hazard) begin
                stall_fetch    = 1'b1;
                stall_decode   = 1'b1;
                bubble_execute = 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_fetch),
        .count (stall_cycles)
    );

    sat_counter #(
        .WIDTH (16)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect_valid),
        .count (flush_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Scoreboard bench for pipeline_hazard_controller (two PERF_W builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    localparam int LAT = 32;

    typedef struct packed {
        logic        stall_fetch;
        logic        stall_decode;
        logic        flush_decode;
        logic        bubble_execute;
        logic        redirect_valid;
        logic [31:0] redirect_pc;
        logic        mdu_busy;
        logic        overlap_err;
        logic [15:0] flush_count;
        logic [31:0] stall_cycles;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_uses_rt = 1'b0;
    logic        id_mdu_op = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rt = '0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] ex_branch_target = '0;
    logic        mdu_start = 1'b0;

    logic        stall_fetch, stall_decode, flush_decode, bubble_execute, redirect_valid;
    logic [31:0] redirect_pc;
    logic        mdu_busy, mdu_overlap_err;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    logic        stall_fetch_4, stall_decode_4, flush_decode_4, bubble_execute_4, redirect_valid_4;
    logic [31:0] redirect_pc_4;
    logic        mdu_busy_4, mdu_overlap_err_4;
    logic [3:0]  stall_cycles_4;
    logic [15:0] flush_count_4;

    int nchecks = 0;
    int nerrors = 0;

    obs_t  exp_q[$];
    obs_t  exp4_q[$];
    string name_q[$];

    int     m_left = 0;
    bit     m_err = 1'b0;
    longint m_sc = 0;
    int     m_sc4 = 0;
    int     m_fc = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.MDU_LATENCY(LAT), .PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_mdu_op(id_mdu_op), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .mdu_start(mdu_start), .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .flush_decode(flush_decode), .bubble_execute(bubble_execute),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mdu_busy(mdu_busy),
        .mdu_overlap_err(mdu_overlap_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_hazard_controller #(.MDU_LATENCY(LAT), .PERF_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_mdu_op(id_mdu_op), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .mdu_start(mdu_start), .stall_fetch(stall_fetch_4), .stall_decode(stall_decode_4),
        .flush_decode(flush_decode_4), .bubble_execute(bubble_execute_4),
        .redirect_valid(redirect_valid_4), .redirect_pc(redirect_pc_4), .mdu_busy(mdu_busy_4),
        .mdu_overlap_err(mdu_overlap_err_4), .stall_cycles(stall_cycles_4), .flush_count(flush_count_4)
    );

    task automatic chk(input string name, input longint act, input longint expv);
        nchecks++;
        if (act != expv) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Drive one cycle of inputs, push the expected response, then advance the model.
    task automatic step(input string name, input bit rst, input bit [4:0] rs, input bit [4:0] rt,
                        input bit uses_rt, input bit mdu_op, input bit mem_read,
                        input bit [4:0] ert, input bit bt, input bit [31:0] tgt, input bit start);
        obs_t e;
        obs_t e4;
        bit   busy;
        bit   lu;
        @(posedge clk);
        #1;
        rst_n = rst; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_mdu_op = mdu_op;
        ex_mem_read = mem_read; ex_rt = ert; ex_branch_taken = bt; ex_branch_target = tgt;
        mdu_start = start;
        if (!rst) begin
            m_left = 0; m_err = 1'b0; m_sc = 0; m_sc4 = 0; m_fc = 0;
        end
        busy = (m_left > 0);
        lu   = mem_read && (ert != 5'd0) && ((ert == rs) || (uses_rt && (ert == rt)));
        e = '0;
        e.redirect_pc = tgt;
        if (rst) begin
            if (bt) begin
                e.flush_decode = 1'b1; e.bubble_execute = 1'b1; e.redirect_valid = 1'b1;
            end else if (lu || (busy && mdu_op)) begin
                e.stall_fetch = 1'b1; e.stall_decode = 1'b1; e.bubble_execute = 1'b1;
            end
        end
        e.mdu_busy     = busy;
        e.overlap_err  = m_err;
        e.flush_count  = 16'(m_fc);
        e.stall_cycles = 32'(m_sc);
        e4 = e;
        e4.stall_cycles = 32'(m_sc4);
        exp_q.push_back(e);
        exp4_q.push_back(e4);
        name_q.push_back(name);
        if (rst) begin
            if (e.stall_fetch) begin
                if (m_sc < 64'hFFFF_FFFF) m_sc++;
                if (m_sc4 < 15) m_sc4++;
            end
            if (e.redirect_valid && (m_fc < 16'hFFFF)) m_fc++;
            if (busy) begin
                if (start) m_err = 1'b1;
                m_left--;
            end else if (start) begin
                m_left = LAT;
            end
        end
    endtask

    task automatic idle(input string name, input int n);
        for (int i = 0; i < n; i++) step(name, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    // Monitor: every negedge with a pending expectation, compare both builds.
    obs_t  mon_e, mon_e4, mon_a, mon_a4;
    string mon_name;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e    = exp_q.pop_front();
            mon_e4   = exp4_q.pop_front();
            mon_name = name_q.pop_front();
            mon_a = '{stall_fetch, stall_decode, flush_decode, bubble_execute, redirect_valid,
                      redirect_pc, mdu_busy, mdu_overlap_err, flush_count, stall_cycles};
            mon_a4 = '{stall_fetch_4, stall_decode_4, flush_decode_4, bubble_execute_4,
                       redirect_valid_4, redirect_pc_4, mdu_busy_4, mdu_overlap_err_4,
                       flush_count_4, {28'd0, stall_cycles_4}};
            nchecks++;
            if (mon_a !== mon_e) begin
                nerrors++;
                $display("FAIL %s (perf32): got %h expected %h", mon_name, mon_a, mon_e);
            end
            nchecks++;
            if (mon_a4 !== mon_e4) begin
                nerrors++;
                $display("FAIL %s (perf4): got %h expected %h", mon_name, mon_a4, mon_e4);
            end
        end
    end

    longint sc0;

    initial begin
        step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        step("reset", 0, 5, 0, 0, 1, 1, 5, 0, 32'h0, 0);
        idle("post_reset", 2);

        step("load_use_rs", 1, 5, 0, 0, 0, 1, 5, 0, 32'h0, 0);
        idle("after_load_use", 1);
        step("load_r0", 1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        step("load_use_rt", 1, 3, 7, 1, 0, 1, 7, 0, 32'h0, 0);
        step("rt_not_used", 1, 3, 7, 0, 0, 1, 7, 0, 32'h0, 0);

        // MDU start then hold id_mdu_op across the whole busy window.
        step("mdu_start", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        @(negedge clk);
        sc0 = longint'(stall_cycles);
        for (int k = 1; k <= LAT + 2; k++) step("mdu_window", 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        chk("mdu_stall_total", longint'(stall_cycles) - sc0, 32);

        step("branch_over_load_use", 1, 5, 0, 0, 0, 1, 5, 1, 32'h0040_0100, 0);
        step("after_branch", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        chk("flush_count_after_branch", longint'(flush_count), 1);

        // Overlapping start at busy cycle 5, branch at busy cycle 10.
        step("mdu_start2", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        for (int k = 1; k <= LAT + 2; k++)
            step("mdu_overlap", 1, 0, 0, 0, 0, 0, 0, (k == 10), 32'h1234_5678, (k == 5));
        @(negedge clk);
        chk("overlap_err_sticky", longint'(mdu_overlap_err), 1);

        // Start and branch together, then reset at busy cycle 7.
        step("start_and_branch", 1, 0, 0, 0, 1, 0, 0, 1, 32'h0040_0200, 1);
        for (int k = 1; k <= 6; k++) step("busy_pre_reset", 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        step("reset_mid_busy", 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        step("after_reset_release", 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        idle("idle", 1);

        // Continuous load-use stall saturates the 4-bit counter.
        for (int k = 0; k < 20; k++) step("saturate", 1, 9, 0, 0, 0, 1, 9, 0, 32'h0, 0);
        idle("idle_end", 2);
        @(negedge clk);
        chk("perf4_saturated", longint'(stall_cycles_4), 15);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
`default_nettype wire
